// File: rtl/mobo_mem_responder_pkg.sv
// mobo_mem_responder_pkg
// Shared mobo command/status encodings. The CPU side and the memory responder
// both import these, so a CPU-side mobo_ctrl value and a responder-side
// mobo_stat value always mean the same thing to both.
// The responder's own FSM state encoding is kept inside the responder.
// Contents:
//   mobo_ctrl_e : CTRL_NONE / CTRL_READ / CTRL_WRITE request codes
//   mobo_stat_e : STAT_IDLE / STAT_BUSY / STAT_DONE / STAT_ERR status codes
//   MOBO_CODE_BITS : number of bits that carry an encoding
package mobo_mem_responder_pkg;

  localparam int MOBO_CODE_BITS = 2;

  typedef enum logic [MOBO_CODE_BITS-1:0] {
    CTRL_NONE  = 2'd0,
    CTRL_READ  = 2'd1,
    CTRL_WRITE = 2'd2
  } mobo_ctrl_e;

  typedef enum logic [MOBO_CODE_BITS-1:0] {
    STAT_IDLE = 2'd0,
    STAT_BUSY = 2'd1,
    STAT_DONE = 2'd2,
    STAT_ERR  = 2'd3
  } mobo_stat_e;

endpackage

// File: rtl/mobo_mem_responder_if.sv
// mobo_mem_responder_if
// Request/response bus between the CPU (master) and the memory responder
// (slave). Every signal is one WORD_WIDTH-bit word.
// Signals:
//   mobo_ctrl : master -> slave, request command
//   addr      : master -> slave, word address
//   data_in   : master -> slave, write data
//   mobo_stat : slave -> master, registered responder status
//   data_out  : slave -> master, read data
interface mobo_mem_responder_if #(
  parameter int WORD_WIDTH = 32
);

  logic [WORD_WIDTH-1:0] mobo_ctrl;
  logic [WORD_WIDTH-1:0] mobo_stat;
  logic [WORD_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] data_in;
  logic [WORD_WIDTH-1:0] data_out;

  modport master (
    output mobo_ctrl,
    output addr,
    output data_in,
    input  mobo_stat,
    input  data_out
  );

  modport slave (
    input  mobo_ctrl,
    input  addr,
    input  data_in,
    output mobo_stat,
    output data_out
  );

endinterface

// File: rtl/mobo_mem_responder_mem_array.sv
// mobo_mem_array
// Single-port word memory with 2^ADDR_BITS entries: synchronous write and
// registered read. The contents and the read register are not reset.
// Ports:
//   clk   : clock
//   we    : write enable, stores wdata at addr on the rising edge
//   re    : read enable, loads rdata from addr on the rising edge
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
module mobo_mem_array #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mobo_mem_responder.sv
// mobo_mem_responder
// Memory responder on the mobo bus. A READ or WRITE seen in idle is latched,
// held busy for WAIT_CYCLES extra cycles, committed to mobo_mem_array, and
// reported as done until the CPU returns mobo_ctrl to CTRL_NONE.
// mobo_stat is registered from the FSM state, so STAT_DONE becomes visible
// WAIT_CYCLES+2 edges after the edge that sampled the request.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active low
//   bus : mobo_mem_responder_if slave modport (mobo_ctrl, addr, data_in in;
//         mobo_stat, data_out out)
// Build option:
//   MOBO_RESP_ADDR_CHECK_EN : when defined, addresses with bits set above
//   ADDR_BITS-1 end in S_ERR (STAT_ERR) without touching memory; otherwise
//   the upper bits are ignored and addresses alias into the array.
//
// state  | meaning
// S_IDLE | waiting for CTRL_READ / CTRL_WRITE
// S_BUSY | request latched, wait counter running down
// S_DONE | access committed, waiting for CTRL_NONE
// S_ERR  | out-of-range address, waiting for CTRL_NONE
module mobo_mem_responder
  import mobo_mem_responder_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mobo_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  state_e                state_q;
  state_e                state_d;
  mobo_stat_e            stat_d;
  mobo_stat_e            stat_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  op_write_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [WORD_WIDTH-1:0] data_q;
  logic                  rd_fill_q;
  logic [WORD_WIDTH-1:0] data_out_q;
  logic [WORD_WIDTH-1:0] mem_rdata;
  logic                  mem_we;
  logic                  mem_re;
  logic                  req_access;
  logic                  req_none;
  logic                  cnt_zero;
  logic                  addr_err;

  assign req_access = (bus.mobo_ctrl == WORD_WIDTH'(CTRL_READ)) ||
                      (bus.mobo_ctrl == WORD_WIDTH'(CTRL_WRITE));
  assign req_none   = (bus.mobo_ctrl == WORD_WIDTH'(CTRL_NONE));
  assign cnt_zero   = (cnt_q == '0);

`ifdef MOBO_RESP_ADDR_CHECK_EN
  // Range check is resolved at sampling time so the full address word
  // need not be carried through the busy phase.
  logic addr_oor_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_oor_q <= 1'b0;
    end else if (state_q == S_IDLE && req_access) begin
      addr_oor_q <= |(bus.addr >> ADDR_BITS);
    end
  end

  assign addr_err = addr_oor_q;
`else
  assign addr_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_access) state_d = S_BUSY;
      S_BUSY: if (cnt_zero)   state_d = addr_err ? S_ERR : S_DONE;
      S_DONE: if (req_none)   state_d = S_IDLE;
      S_ERR:  if (req_none)   state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Output logic: status code and memory strobes for the commit edge
  always_comb begin
    stat_d = STAT_IDLE;
    mem_we = 1'b0;
    mem_re = 1'b0;
    case (state_q)
      S_BUSY: begin
        stat_d = STAT_BUSY;
        if (cnt_zero && !addr_err) begin
          mem_we = op_write_q;
          mem_re = !op_write_q;
        end
      end
      S_DONE: stat_d = STAT_DONE;
`ifdef MOBO_RESP_ADDR_CHECK_EN
      S_ERR:  stat_d = STAT_ERR;
`endif
      default: stat_d = STAT_IDLE;
    endcase
  end

  // Request latches and wait counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else if (state_q == S_IDLE && req_access) begin
      cnt_q      <= CNT_LOAD;
      op_write_q <= (bus.mobo_ctrl == WORD_WIDTH'(CTRL_WRITE));
      addr_q     <= bus.addr[ADDR_BITS-1:0];
      data_q     <= bus.data_in;
    end else if (state_q == S_BUSY && !cnt_zero) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Status register and read-data capture. The array's read register
  // lands on the commit edge; data_out takes it one edge later, which is
  // the same edge on which mobo_stat turns STAT_DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_q     <= STAT_IDLE;
      rd_fill_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      stat_q    <= stat_d;
      rd_fill_q <= mem_re;
      if (rd_fill_q) begin
        data_out_q <= mem_rdata;
      end
    end
  end

  // A reset on the commit edge must not let a pending write through.
  mobo_mem_array #(
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we & rst),
    .re    (mem_re & rst),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (mem_rdata)
  );

  assign bus.mobo_stat = WORD_WIDTH'(stat_q);
  assign bus.data_out  = data_out_q;

endmodule

// File: tb/tb_mobo_mem_responder.sv
// tb_mobo_mem_responder
// Directed bench for mobo_mem_responder. u_dut_a uses WAIT_CYCLES=2 and
// u_dut_b uses WAIT_CYCLES=0; both share clk and rst.
module tb_mobo_mem_responder;
  import mobo_mem_responder_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] C_NONE  = W'(CTRL_NONE);
  localparam logic [W-1:0] C_READ  = W'(CTRL_READ);
  localparam logic [W-1:0] C_WRITE = W'(CTRL_WRITE);
  localparam logic [W-1:0] S_IDLE_V = W'(STAT_IDLE);
  localparam logic [W-1:0] S_BUSY_V = W'(STAT_BUSY);
  localparam logic [W-1:0] S_DONE_V = W'(STAT_DONE);
  localparam logic [W-1:0] S_ERR_V  = W'(STAT_ERR);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mobo_mem_responder_if #(.WORD_WIDTH(W)) bus_a ();
  mobo_mem_responder_if #(.WORD_WIDTH(W)) bus_b ();

  mobo_mem_responder #(.WORD_WIDTH(W), .ADDR_BITS(8), .WAIT_CYCLES(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mobo_mem_responder #(.WORD_WIDTH(W), .ADDR_BITS(8), .WAIT_CYCLES(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic [W-1:0] ctrl,
                       input logic [W-1:0] a, input logic [W-1:0] d);
    if (sel) begin
      bus_b.mobo_ctrl = ctrl;
      bus_b.addr      = a;
      bus_b.data_in   = d;
    end else begin
      bus_a.mobo_ctrl = ctrl;
      bus_a.addr      = a;
      bus_a.data_in   = d;
    end
  endtask

  function automatic logic [W-1:0] stat_of(input bit sel);
    return sel ? bus_b.mobo_stat : bus_a.mobo_stat;
  endfunction

  function automatic logic [W-1:0] dout_of(input bit sel);
    return sel ? bus_b.data_out : bus_a.data_out;
  endfunction

  // Issue one request, optionally changing addr/data after the sampling
  // edge, check exact busy/done latency, hold the command for 'hold'
  // cycles in the final state, then release to CTRL_NONE and check idle.
  task automatic access(input bit sel, input logic [W-1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] d,
                        input logic [W-1:0] a2, input logic [W-1:0] d2,
                        input int wt, input int hold,
                        input logic [W-1:0] fin, input string tag);
    drive(sel, op, a, d);
    tick(1);
    drive(sel, op, a2, d2);
    tick(1);
    chk({tag, "_busy"}, stat_of(sel), S_BUSY_V);
    if (wt > 0) begin
      tick(wt);
      chk({tag, "_prefin"}, stat_of(sel), S_BUSY_V);
    end
    tick(1);
    chk({tag, "_fin"}, stat_of(sel), fin);
    for (int i = 0; i < hold; i++) begin
      tick(1);
      chk({tag, "_hold"}, stat_of(sel), fin);
    end
    drive(sel, C_NONE, a2, d2);
    tick(2);
    chk({tag, "_idle"}, stat_of(sel), S_IDLE_V);
  endtask

  initial begin
    drive(1'b0, C_NONE, '0, '0);
    drive(1'b1, C_NONE, '0, '0);
    rst = 1'b0;
    tick(3);
    chk("rst_stat_a", stat_of(1'b0), S_IDLE_V);
    chk("rst_dout_a", dout_of(1'b0), '0);
    chk("rst_stat_b", stat_of(1'b1), S_IDLE_V);
    rst = 1'b1;
    tick(1);

    // write 5 to 3, read it back
    access(1'b0, C_WRITE, 32'd3, 32'd5, 32'd3, 32'd5, 2, 0, S_DONE_V, "wr3");
    access(1'b0, C_READ,  32'd3, 32'd0, 32'd3, 32'd0, 2, 0, S_DONE_V, "rd3");
    chk("rd3_data", dout_of(1'b0), 32'd5);

    // command held past done; data_out keeps last read value across a write
    access(1'b0, C_WRITE, 32'd10, 32'h22, 32'd10, 32'h22, 2, 5, S_DONE_V, "wr10_hold");
    chk("dout_hold_after_wr", dout_of(1'b0), 32'd5);
    access(1'b0, C_READ, 32'd10, 32'd0, 32'd10, 32'd0, 2, 0, S_DONE_V, "rd10");
    chk("rd10_data", dout_of(1'b0), 32'h22);

    // inputs changed during busy are ignored
    access(1'b0, C_WRITE, 32'd7, 32'h77, 32'd7, 32'h77, 2, 0, S_DONE_V, "wr7");
    access(1'b0, C_WRITE, 32'd3, 32'd5, 32'd7, 32'd9, 2, 0, S_DONE_V, "wr3_chg");
    access(1'b0, C_READ, 32'd3, 32'd0, 32'd3, 32'd0, 2, 0, S_DONE_V, "rd3_chg");
    chk("rd3_chg_data", dout_of(1'b0), 32'd5);
    access(1'b0, C_READ, 32'd7, 32'd0, 32'd7, 32'd0, 2, 0, S_DONE_V, "rd7_chg");
    chk("rd7_chg_data", dout_of(1'b0), 32'h77);

    // reset on first busy edge aborts the write
    access(1'b0, C_WRITE, 32'd1, 32'h11, 32'd1, 32'h11, 2, 0, S_DONE_V, "wr1");
    drive(1'b0, C_WRITE, 32'd1, 32'hAA);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("abort_stat", stat_of(1'b0), S_IDLE_V);
    chk("abort_dout", dout_of(1'b0), '0);
    rst = 1'b1;
    drive(1'b0, C_NONE, 32'd1, 32'hAA);
    tick(1);
    chk("abort_idle", stat_of(1'b0), S_IDLE_V);
    access(1'b0, C_READ, 32'd1, 32'd0, 32'd1, 32'd0, 2, 0, S_DONE_V, "rd1");
    chk("rd1_data", dout_of(1'b0), 32'h11);

    // out-of-range address
    access(1'b0, C_WRITE, 32'd0, 32'hC0DE, 32'd0, 32'hC0DE, 2, 0, S_DONE_V, "wr0");
`ifdef MOBO_RESP_ADDR_CHECK_EN
    access(1'b0, C_READ, 32'h100, 32'd0, 32'h100, 32'd0, 2, 0, S_ERR_V, "rd_oor");
    chk("rd_oor_data", dout_of(1'b0), 32'h11);
`else
    access(1'b0, C_READ, 32'h100, 32'd0, 32'h100, 32'd0, 2, 0, S_DONE_V, "rd_alias");
    chk("rd_alias_data", dout_of(1'b0), 32'hC0DE);
    chk("no_err_stat", stat_of(1'b0) == S_ERR_V ? 32'd1 : 32'd0, 32'd0);
`endif

    // WAIT_CYCLES=0 instance: undefined ctrl ignored, 2-edge latency
    drive(1'b1, 32'd3, 32'd2, 32'h5A);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("b_ctrl3_idle", stat_of(1'b1), S_IDLE_V);
    end
    access(1'b1, C_WRITE, 32'd2, 32'h5A, 32'd2, 32'h5A, 0, 0, S_DONE_V, "b_wr2");
    access(1'b1, C_READ,  32'd2, 32'd0, 32'd2, 32'd0, 0, 0, S_DONE_V, "b_rd2");
    chk("b_rd2_data", dout_of(1'b1), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
